fetch_unit: RTL and testbench

- Parametrised, decoupled instruction-fetch front end for the 16-bit processor core.
- Replaces the free-running pc-plus-two fetch path.
- Issues requests to instruction memory over a req/ack handshake that tolerates variable latency, and buffers returned instructions with their PCs in a small queue.
- Presents them to decode with valid/ready, and supports redirect (branch/jump) with flush and halt.

---
 rtl/fetch_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - decoupled instruction-fetch front end with PC/instruction queue
//
// Purpose:
//   Issues instruction-memory requests over a req/ack handshake that tolerates
//   any latency (including a same-cycle ack) and keeps at most one request
//   outstanding. Returned instructions are queued together with their PCs and
//   handed to decode through a valid/ready interface. A redirect flushes the
//   queue and restarts fetch. A request that is in flight at the time of the
//   redirect is completed and its data dropped (DRAIN state). Halt stops new
//   requests without disturbing the one in flight.
//
// Optional feature:
//   FETCH_PERF_EN - adds 32-bit wrapping counters perf_fetched (pops) and
//                   perf_stall (cycles with decode ready but queue empty).
//
// Ports:
//   clk            in   clock
//   rst            in   asynchronous active-low reset
//   imem_req       out  fetch request, held until imem_ack
//   imem_addr      out  fetch address, stable while imem_req is high
//   imem_ack       in   memory response valid (may coincide with imem_req)
//   imem_rdata     in   instruction data, valid with imem_ack
//   instr_valid    out  queue head valid
//   instr          out  head instruction (0 when instr_valid is low)
//   instr_pc       out  PC of head instruction (0 when instr_valid is low)
//   instr_ready    in   decode accepts the head this cycle
//   redirect_valid in   flush and restart fetch at redirect_pc
//   redirect_pc    in   new fetch PC (bit 0 ignored)
//   halt           in   stop issuing new requests
//   perf_fetched   out  [FETCH_PERF_EN] instructions popped by decode
//   perf_stall     out  [FETCH_PERF_EN] cycles decode waited on an empty queue

module fetch_unit #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned QDEPTH   = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] PC_INC   = ADDR_W'(DATA_W / 8);
    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);
    localparam logic [CNT_W-1:0]  Q_FULL   = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Queue storage has no reset: count_q alone decides what is valid.
    logic [DATA_W-1:0] data_mem_q [QDEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [QDEPTH];

    logic req_raw;
    logic ack_wanted;
    logic push;
    logic pop;

    // Bit 0 of the redirect target is discarded (halfword-aligned PCs).
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = redirect_pc[0];

    // ------------------------------------------------------------------
    // Request, queue and next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // Once a request is out it is held until ack, regardless of halt
        // or queue occupancy. New requests need space so a push can never
        // overflow, even when no pop happens that cycle.
        req_raw   = (state_q != S_IDLE) || (!halt && (count_q < Q_FULL));
        // Gated by reset so the request drops the instant reset asserts.
        imem_req  = rst && req_raw;
        imem_addr = (state_q == S_DRAIN) ? drain_addr_q : fetch_pc_q;

        instr_valid = (count_q != '0);
        instr       = instr_valid ? data_mem_q[rd_ptr_q] : '0;
        instr_pc    = instr_valid ? pc_mem_q[rd_ptr_q]   : '0;

        // Data is wanted only for a live request that is not being drained.
        ack_wanted = imem_ack && imem_req && (state_q != S_DRAIN);
        push       = ack_wanted && !redirect_valid;
        pop        = instr_valid && instr_ready && !redirect_valid;

        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                // A request issued under a redirect with no same-cycle ack
                // is already on the bus, so its data has to be drained.
                if (imem_req && !imem_ack) begin
                    state_d = redirect_valid ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    state_d = S_IDLE;
                end else if (redirect_valid) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Remember the abandoned address so imem_addr stays stable while
        // fetch_pc_q already points at the redirect target.
        drain_addr_d = drain_addr_q;
        if ((state_q != S_DRAIN) && (state_d == S_DRAIN)) begin
            drain_addr_d = fetch_pc_q;
        end

        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[ADDR_W-1:1], 1'b0};
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + PC_INC;
        end

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= PC_RESET;
            drain_addr_q <= PC_RESET;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            drain_addr_q <= drain_addr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

`ifdef FETCH_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (free-running, wrap on overflow)
    // ------------------------------------------------------------------
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (pop) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (instr_ready && !instr_valid) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit

module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;

    int n_cmp = 0;
    int n_bad = 0;

    // Memory model: ack after 'lat' cycles of held request, data derived
    // from the address so every instruction is distinguishable.
    int   lat = 0;
    int   wait_cnt = 0;
    logic stray_ack = 1'b0;

    function automatic logic [15:0] dfun(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3C3;
    endfunction

    assign imem_ack   = (imem_req && (wait_cnt >= lat)) || stray_ack;
    assign imem_rdata = dfun(imem_addr);

    fetch_unit #(
        .ADDR_W(16), .DATA_W(16), .QDEPTH(4), .RESET_PC(0)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Latency counter: sample handshake at the edge, update at the negedge.
    initial begin
        logic a, r;
        forever begin
            @(posedge clk);
            a = imem_ack;
            r = imem_req;
            @(negedge clk);
            if (a || !r) wait_cnt = 0;
            else wait_cnt = wait_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ev, input logic [15:0] epc,
                            input logic ereq, input logic [15:0] eaddr);
        chk({tag, " instr_valid"}, {31'd0, instr_valid}, {31'd0, ev});
        chk({tag, " instr_pc"}, {16'd0, instr_pc}, {16'd0, ev ? epc : 16'h0000});
        chk({tag, " instr"}, {16'd0, instr}, {16'd0, ev ? dfun(epc) : 16'h0000});
        chk({tag, " imem_req"}, {31'd0, imem_req}, {31'd0, ereq});
        chk({tag, " imem_addr"}, {16'd0, imem_addr}, {16'd0, eaddr});
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        halt = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0;
        stray_ack = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic        rst_n;
        logic        ready;
        logic        exp_valid;
        logic [15:0] exp_pc;
        logic        exp_req;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t vq[$];

    initial begin
        int i;
        rst = 1'b0;
        halt = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0;
        instr_ready = 1'b0;

        // Zero-latency streaming, then back-pressure fill and release.
        vq.push_back('{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000});
        vq.push_back('{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000});
        vq.push_back('{1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0002});
        vq.push_back('{1'b1, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0004});
        vq.push_back('{1'b1, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0006});
        vq.push_back('{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000});
        vq.push_back('{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000});
        vq.push_back('{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0002});
        vq.push_back('{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0004});
        vq.push_back('{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0006});
        for (int k = 0; k < 6; k++)
            vq.push_back('{1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0008});
        vq.push_back('{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0008});
        vq.push_back('{1'b1, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0008});
        vq.push_back('{1'b1, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h000A});
        vq.push_back('{1'b1, 1'b1, 1'b1, 16'h0006, 1'b1, 16'h000C});
        vq.push_back('{1'b1, 1'b1, 1'b1, 16'h0008, 1'b1, 16'h000E});

        lat = 0;
        @(negedge clk);
        foreach (vq[k]) begin
            rst = vq[k].rst_n;
            instr_ready = vq[k].ready;
            #2;
            chk_outs($sformatf("vec%0d", k), vq[k].exp_valid, vq[k].exp_pc,
                     vq[k].exp_req, vq[k].exp_addr);
            @(negedge clk);
        end

        // Redirect while a 3-cycle request is outstanding.
        lat = 3;
        do_reset();
        #2 chk_outs("redir c0", 1'b0, 16'h0, 1'b1, 16'h0000);
        cyc(); cyc(); cyc(); cyc();
        #2 chk_outs("redir c4", 1'b1, 16'h0000, 1'b1, 16'h0002);
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0101;
        #2 chk_outs("redir c5", 1'b1, 16'h0000, 1'b1, 16'h0002);
        cyc();
        redirect_valid = 1'b0;
        #2 chk_outs("redir drain", 1'b0, 16'h0, 1'b1, 16'h0002);
        cyc();
        #2 chk_outs("redir drain ack", 1'b0, 16'h0, 1'b1, 16'h0002);
        cyc();
        #2 chk_outs("redir restart", 1'b0, 16'h0, 1'b1, 16'h0100);
        instr_ready = 1'b1;
        i = 0;
        while (!instr_valid && i < 20) begin
            cyc();
            #2;
            i++;
        end
        chk("redir first valid (timeout)", {31'd0, instr_valid}, 32'd1);
        chk("redir first pc", {16'd0, instr_pc}, 32'h0100);
        chk("redir first instr", {16'd0, instr}, {16'd0, dfun(16'h0100)});

        // PC wrap at the top of the address space.
        lat = 0;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFE;
        #2 chk_outs("wrap c0", 1'b0, 16'h0, 1'b1, 16'h0000);
        cyc();
        redirect_valid = 1'b0;
        #2 chk_outs("wrap c1", 1'b0, 16'h0, 1'b1, 16'hFFFE);
        cyc();
        instr_ready = 1'b1;
        #2 chk_outs("wrap c2", 1'b1, 16'hFFFE, 1'b1, 16'h0000);
        cyc();
        #2 chk_outs("wrap c3", 1'b1, 16'h0000, 1'b1, 16'h0002);

        // Halt with a request outstanding.
        lat = 2;
        do_reset();
        instr_ready = 1'b1;
        #2 chk_outs("halt c0", 1'b0, 16'h0, 1'b1, 16'h0000);
        cyc();
        halt = 1'b1;
        #2 chk_outs("halt c1", 1'b0, 16'h0, 1'b1, 16'h0000);
        cyc();
        #2 chk_outs("halt c2", 1'b0, 16'h0, 1'b1, 16'h0000);
        cyc();
        #2 chk_outs("halt c3", 1'b1, 16'h0000, 1'b0, 16'h0002);
        cyc();
        #2 chk_outs("halt c4", 1'b0, 16'h0, 1'b0, 16'h0002);
        cyc();
        halt = 1'b0;
        #2 chk_outs("halt resume", 1'b0, 16'h0, 1'b1, 16'h0002);

        // Reset asserted in WAIT, then a stray ack.
        lat = 3;
        do_reset();
        cyc();
        #2 chk_outs("rstmid wait", 1'b0, 16'h0, 1'b1, 16'h0000);
        rst = 1'b0;
        #2 chk_outs("rstmid async", 1'b0, 16'h0, 1'b0, 16'h0000);
        cyc();
        rst = 1'b1;
        halt = 1'b1;
        stray_ack = 1'b1;
        #2 chk_outs("rstmid stray", 1'b0, 16'h0, 1'b0, 16'h0000);
        cyc();
        stray_ack = 1'b0;
        halt = 1'b0;
        lat = 0;
        #2 chk_outs("rstmid nopush", 1'b0, 16'h0, 1'b1, 16'h0000);
        cyc();
        #2 chk_outs("rstmid restart", 1'b1, 16'h0000, 1'b1, 16'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
